// File: rtl/text_screen_pkg.sv
// Shared types and constants for the text prompt screen: FSM states, palette
// and font geometry.
package text_screen_pkg;

  typedef enum logic [1:0] {IDLE, HOLD, PROMPT, ACK} state_t;

  localparam logic [3:0] BG_R = 4'd3;
  localparam logic [3:0] BG_G = 4'd6;
  localparam logic [3:0] BG_B = 4'd2;
  localparam logic [3:0] FG_R = 4'hE;
  localparam logic [3:0] FG_G = 4'hE;
  localparam logic [3:0] FG_B = 4'hC;

  localparam logic [6:0] ASCII_SPACE = 7'd32;
  localparam int FONT_ROWS = 16;
  localparam int GLYPH_W   = 8;

endpackage

// File: rtl/text_pixel_pipe.sv
// Two-stage render path: box test and font addressing, then glyph bit select.
// Optional 2-pixel border ring when TEXT_PROMPT_BORDER_EN is defined.
module text_pixel_pipe
  import text_screen_pkg::*;
#(
  parameter int MAX_CHARS  = 16,
  parameter int SCALE_LOG2 = 2,
  parameter int X0         = 100,
  parameter int Y0         = 100,
  parameter int LEN_W      = $clog2(MAX_CHARS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [9:0]       draw_x,
  input  logic [9:0]       draw_y,
  input  logic [LEN_W-1:0] len,
  input  logic             text_enable,
`ifdef TEXT_PROMPT_BORDER_EN
  input  logic             border_enable,
`endif
  input  logic [6:0]       char_code,
  input  logic [7:0]       font_data,
  output logic [9:0]       char_sel,
  output logic [10:0]      font_address,
  output logic [3:0]       red,
  output logic [3:0]       green,
  output logic [3:0]       blue
);

  localparam logic [11:0] BOX_W = 12'(GLYPH_W << SCALE_LOG2);
  localparam logic [11:0] BOX_H = 12'(FONT_ROWS << SCALE_LOG2);
  localparam logic [11:0] X_LO  = 12'(X0);
  localparam logic [11:0] Y_LO  = 12'(Y0);

  logic [11:0] x_ext, y_ext, x_end, y_end;
  logic        in_box;
  logic [9:0]  dx, dy;
  logic [2:0]  col;
  logic [3:0]  row;
  logic        in_box_d, text_en_d, pixel_on;
  logic [2:0]  col_d;

  // Box bounds are evaluated in 12 bits so a long string never wraps.
  assign x_ext  = {2'b00, draw_x};
  assign y_ext  = {2'b00, draw_y};
  assign x_end  = X_LO + 12'(len) * BOX_W;
  assign y_end  = Y_LO + BOX_H;
  assign in_box = (x_ext >= X_LO) && (x_ext < x_end) && (y_ext >= Y_LO) && (y_ext < y_end);

  assign dx           = in_box ? (draw_x - 10'(X0)) : 10'd0;
  assign dy           = in_box ? (draw_y - 10'(Y0)) : 10'd0;
  assign char_sel     = dx >> (3 + SCALE_LOG2);
  assign col          = 3'(dx >> SCALE_LOG2);
  assign row          = 4'(dy >> SCALE_LOG2);
  assign font_address = in_box ? ({char_code, 4'b0000} + {7'b0, row}) : 11'd0;

`ifdef TEXT_PROMPT_BORDER_EN
  logic in_ring, ring_d;
  assign in_ring = border_enable && !in_box &&
                   (x_ext + 12'd2 >= X_LO) && (x_ext < x_end + 12'd2) &&
                   (y_ext + 12'd2 >= Y_LO) && (y_ext < y_end + 12'd2);

  always_ff @(posedge clk) begin
    if (reset) ring_d <= 1'b0;
    else       ring_d <= in_ring;
  end

  assign pixel_on = (in_box_d & text_en_d & font_data[3'd7 - col_d]) | ring_d;
`else
  assign pixel_on = in_box_d & text_en_d & font_data[3'd7 - col_d];
`endif

  // Stage 0 state travels alongside the font ROM's one-cycle read.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_box_d  <= 1'b0;
      text_en_d <= 1'b0;
      col_d     <= 3'd0;
    end else begin
      in_box_d  <= in_box;
      text_en_d <= text_enable;
      col_d     <= col;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || !pixel_on) begin
      red   <= BG_R;
      green <= BG_G;
      blue  <= BG_B;
    end else begin
      red   <= FG_R;
      green <= FG_G;
      blue  <= FG_B;
    end
  end

endmodule

// File: rtl/text_prompt_screen.sv
// Text prompt screen: string buffer, hold/blink/acknowledge FSM and render pipe.
// Define TEXT_PROMPT_BORDER_EN to draw a border ring around the text box.
module text_prompt_screen
  import text_screen_pkg::*;
#(
  parameter int MAX_CHARS    = 16,
  parameter int SCALE_LOG2   = 2,
  parameter int X0           = 100,
  parameter int Y0           = 100,
  parameter int HOLD_FRAMES  = 60,
  parameter int BLINK_FRAMES = 30,
  localparam int IDX_W       = $clog2(MAX_CHARS),
  localparam int LEN_W       = $clog2(MAX_CHARS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_start,
  input  logic [9:0]       DrawX,
  input  logic [9:0]       DrawY,
  input  logic [7:0]       font_data,
  output logic [10:0]      font_address,
  output logic [3:0]       Red,
  output logic [3:0]       Green,
  output logic [3:0]       Blue,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [6:0]       wr_char,
  input  logic [LEN_W-1:0] str_len,
  input  logic             show,
  input  logic             key_pressed,
  output logic             busy,
  output logic             continue_pulse
);

  state_t           state;
  logic [6:0]       char_buf [MAX_CHARS];
  logic [LEN_W-1:0] len_q;
  logic [15:0]      frame_cnt;
  logic             blink_phase;
  logic [9:0]       char_sel;
  logic [6:0]       rd_char;
  logic             text_enable;
  logic             wr_ok;

  assign wr_ok       = ({1'b0, wr_idx} < (IDX_W + 1)'(MAX_CHARS));
  assign rd_char     = (char_sel < 10'(MAX_CHARS)) ? char_buf[char_sel[IDX_W-1:0]] : ASCII_SPACE;
  assign text_enable = (state == HOLD) || ((state == PROMPT) && !blink_phase);

  // The buffer is only writable in IDLE, so it is updated inside the FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      len_q          <= '0;
      frame_cnt      <= 16'd0;
      blink_phase    <= 1'b0;
      busy           <= 1'b0;
      continue_pulse <= 1'b0;
      for (int i = 0; i < MAX_CHARS; i++) char_buf[i] <= ASCII_SPACE;
    end else begin
      continue_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_en && wr_ok) char_buf[wr_idx] <= wr_char;
          if (show) begin
            state       <= HOLD;
            busy        <= 1'b1;
            frame_cnt   <= 16'd0;
            blink_phase <= 1'b0;
            len_q       <= (str_len > LEN_W'(MAX_CHARS)) ? LEN_W'(MAX_CHARS) : str_len;
          end
        end
        HOLD: begin
          if (frame_start) begin
            if (frame_cnt == 16'(HOLD_FRAMES - 1)) begin
              state     <= PROMPT;
              frame_cnt <= 16'd0;
            end else begin
              frame_cnt <= frame_cnt + 16'd1;
            end
          end
        end
        PROMPT: begin
          if (key_pressed) begin
            state          <= ACK;
            continue_pulse <= 1'b1;
          end else if (frame_start) begin
            if (frame_cnt == 16'(BLINK_FRAMES - 1)) begin
              frame_cnt   <= 16'd0;
              blink_phase <= ~blink_phase;
            end else begin
              frame_cnt <= frame_cnt + 16'd1;
            end
          end
        end
        ACK: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef TEXT_PROMPT_BORDER_EN
  logic border_enable;
  assign border_enable = busy && (len_q != '0);
`endif

  text_pixel_pipe #(
    .MAX_CHARS  (MAX_CHARS),
    .SCALE_LOG2 (SCALE_LOG2),
    .X0         (X0),
    .Y0         (Y0),
    .LEN_W      (LEN_W)
  ) u_pipe (
    .clk          (clk),
    .reset        (reset),
    .draw_x       (DrawX),
    .draw_y       (DrawY),
    .len          (len_q),
    .text_enable  (text_enable),
`ifdef TEXT_PROMPT_BORDER_EN
    .border_enable(border_enable),
`endif
    .char_code    (rd_char),
    .font_data    (font_data),
    .char_sel     (char_sel),
    .font_address (font_address),
    .red          (Red),
    .green        (Green),
    .blue         (Blue)
  );

endmodule

// File: tb/tb_text_prompt_screen.sv
// Bench for text_prompt_screen: directed sequence with randomized pixels and
// noise, checked against a frame-count model of the prompt screen.
module tb_text_prompt_screen;

  localparam int MAXC  = 16;
  localparam int S     = 2;
  localparam int X0    = 100;
  localparam int Y0    = 100;
  localparam int HOLD  = 60;
  localparam int BLINK = 30;
  localparam int IDX_W = $clog2(MAXC);
  localparam int LEN_W = $clog2(MAXC + 1);
  localparam int GW    = 8 << S;
  localparam int GH    = 16 << S;
  localparam logic [11:0] BG = 12'h362;
  localparam logic [11:0] FG = 12'hEEC;

  logic             clk = 1'b0;
  logic             reset, frame_start, wr_en, show, key_pressed;
  logic [9:0]       DrawX, DrawY;
  logic [7:0]       font_data;
  logic [10:0]      font_address;
  logic [3:0]       Red, Green, Blue;
  logic [IDX_W-1:0] wr_idx;
  logic [6:0]       wr_char;
  logic [LEN_W-1:0] str_len;
  logic             busy, continue_pulse;
  logic [11:0]      rgb;

  int errors = 0;
  int checks = 0;

  bit          m_active, m_ack, m_valid;
  int          m_frames, m_len;
  int          m_buf [MAXC];
  logic [11:0] pipe_rgb;

  always #5 clk = ~clk;
  assign rgb = {Red, Green, Blue};

  text_prompt_screen #(
    .MAX_CHARS(MAXC), .SCALE_LOG2(S), .X0(X0), .Y0(Y0),
    .HOLD_FRAMES(HOLD), .BLINK_FRAMES(BLINK)
  ) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start),
    .DrawX(DrawX), .DrawY(DrawY), .font_data(font_data),
    .font_address(font_address), .Red(Red), .Green(Green), .Blue(Blue),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_char(wr_char), .str_len(str_len),
    .show(show), .key_pressed(key_pressed), .busy(busy),
    .continue_pulse(continue_pulse)
  );

  function automatic logic [7:0] rom_row(input logic [10:0] a);
    logic [15:0] t;
    t = {5'b0, a} * 16'd40503;
    return t[15:8] ^ a[7:0];
  endfunction

  // Synchronous font ROM with one cycle of read latency.
  always @(posedge clk) font_data <= rom_row(font_address);

  function automatic bit in_text(input int x, input int y);
    return (x >= X0) && (x < X0 + m_len * GW) && (y >= Y0) && (y < Y0 + GH);
  endfunction

  function automatic int exp_addr(input int x, input int y);
    if (!in_text(x, y)) return 0;
    return m_buf[(x - X0) / GW] * 16 + ((y - Y0) / (1 << S)) % 16;
  endfunction

  function automatic bit text_visible();
    if (!m_active) return 1'b0;
    if (m_frames < HOLD) return 1'b1;
    return (((m_frames - HOLD) / BLINK) % 2) == 0;
  endfunction

  function automatic logic [11:0] exp_rgb(input int x, input int y);
    logic [7:0] row_bits;
    int bit_pos;
    bit on;
    on = 1'b0;
    if (in_text(x, y) && text_visible()) begin
      row_bits = rom_row(11'(exp_addr(x, y)));
      bit_pos  = 7 - ((x - X0) / (1 << S)) % 8;
      on       = row_bits[bit_pos];
    end
`ifdef TEXT_PROMPT_BORDER_EN
    if ((m_active || m_ack) && m_len > 0 && !in_text(x, y) &&
        x >= X0 - 2 && x < X0 + m_len * GW + 2 && y >= Y0 - 2 && y < Y0 + GH + 2)
      on = 1'b1;
`endif
    return on ? FG : BG;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_update(input bit rst, input bit fs, input bit key, input bit sh,
                              input bit we, input int idx, input int ch, input int ln);
    if (rst) begin
      m_active = 1'b0; m_ack = 1'b0; m_len = 0; m_frames = 0; m_valid = 1'b1;
      for (int i = 0; i < MAXC; i++) m_buf[i] = 32;
    end else if (m_ack) begin
      m_ack = 1'b0;
    end else if (!m_active) begin
      if (we && idx < MAXC) m_buf[idx] = ch;
      if (sh) begin
        m_active = 1'b1;
        m_frames = 0;
        m_len    = (ln > MAXC) ? MAXC : ln;
      end
    end else if (m_frames >= HOLD && key) begin
      m_active = 1'b0;
      m_ack    = 1'b1;
    end else if (fs) begin
      m_frames++;
    end
  endtask

  // One clock cycle: drive at posedge+1, check address at negedge, outputs after next edge.
  task automatic applyStimulus(input int x, input int y, input bit fs, input bit key,
                               input bit sh, input bit we, input int idx, input int ch,
                               input int ln, input bit rst);
    logic [11:0] e;
    reset = rst; DrawX = 10'(x); DrawY = 10'(y); frame_start = fs; key_pressed = key;
    show = sh; wr_en = we; wr_idx = IDX_W'(idx); wr_char = 7'(ch); str_len = LEN_W'(ln);
    @(negedge clk);
    if (m_valid) checkOutput("font_address", 32'(font_address), 32'(exp_addr(x, y)));
    e = exp_rgb(x, y);
    @(posedge clk);
    #1;
    model_update(rst, fs, key, sh, we, idx, ch, ln);
    if (rst) begin
      checkOutput("rgb_reset", 32'(rgb), 32'(BG));
      pipe_rgb = BG;
    end else begin
      checkOutput("rgb", 32'(rgb), 32'(pipe_rgb));
      pipe_rgb = e;
    end
    checkOutput("busy", 32'(busy), 32'(m_active || m_ack));
    checkOutput("continue_pulse", 32'(continue_pulse), 32'(m_ack));
  endtask

  task automatic rand_cycle(input bit fs, input bit key, input bit noise);
    int x, y;
    bit sh, we;
    x  = X0 - 4 + int'($urandom_range(0, m_len * GW + 8));
    y  = Y0 - 4 + int'($urandom_range(0, GH + 8));
    sh = noise && ($urandom_range(0, 7) == 0);
    we = noise && ($urandom_range(0, 3) == 0);
    applyStimulus(x, y, fs, key, sh, we, int'($urandom_range(0, MAXC - 1)),
                  int'($urandom_range(0, 127)), int'($urandom_range(0, 31)), 1'b0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int xs [4];
    int ys [4];
    xs = '{99, 100, 163, 164};
    ys = '{99, 100, 163, 164};
    reset = 1'b1; frame_start = 1'b0; key_pressed = 1'b0; show = 1'b0; wr_en = 1'b0;
    wr_idx = '0; wr_char = '0; str_len = '0; DrawX = 10'(X0); DrawY = 10'(Y0);
    pipe_rgb = BG;
    @(posedge clk);
    #1;

    $display("[TB] reset and idle");
    repeat (3) applyStimulus(X0, Y0, 0, 0, 0, 0, 0, 0, 0, 1);
    repeat (2) applyStimulus(X0, Y0, 0, 0, 0, 0, 0, 0, 0, 0);

    $display("[TB] load OK and show");
    applyStimulus(X0, Y0, 0, 0, 0, 1, 0, 79, 0, 0);
    applyStimulus(X0, Y0, 0, 0, 0, 1, 1, 75, 0, 0);
    applyStimulus(X0, Y0, 0, 0, 1, 0, 0, 0, 2, 0);
    applyStimulus(100, 104, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("addr_O_row1", 32'(font_address), 32'd1265);
    applyStimulus(132, 100, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("addr_K_row0", 32'(font_address), 32'd1200);
    foreach (xs[i]) foreach (ys[j]) applyStimulus(xs[i], ys[j], 0, 0, 0, 0, 0, 0, 0, 0);

    $display("[TB] hold phase with ignored keys");
    for (int i = 0; i < HOLD; i++) begin
      rand_cycle(1'b1, ($urandom_range(0, 3) == 0), 1'b1);
      rand_cycle(1'b0, (i < HOLD - 1) && ($urandom_range(0, 3) == 0), 1'b1);
    end

    $display("[TB] prompt blinking");
    for (int i = 0; i < 2 * BLINK + 5; i++) begin
      rand_cycle(1'b1, 1'b0, 1'b1);
      rand_cycle(1'b0, 1'b0, 1'b1);
      rand_cycle(1'b0, 1'b0, 1'b1);
    end

    $display("[TB] key with frame_start");
    applyStimulus(X0 + 5, Y0 + 5, 1, 1, 0, 0, 0, 0, 0, 0);
    checkOutput("ack_pulse", 32'(continue_pulse), 32'd1);
    applyStimulus(X0 + 5, Y0 + 5, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("idle_after_ack", 32'(busy), 32'd0);
    repeat (3) rand_cycle(1'b0, 1'b0, 1'b0);

    $display("[TB] full buffer with clamped length");
    for (int i = 0; i < MAXC; i++)
      applyStimulus(X0, Y0, 0, 0, 0, 1, i, int'($urandom_range(33, 126)), 0, 0);
    applyStimulus(X0, Y0, 0, 0, 1, 0, 0, 0, 20, 0);
    applyStimulus(X0 + MAXC * GW - 1, Y0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(X0 + MAXC * GW, Y0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("addr_past_clamp", 32'(font_address), 32'd0);
    repeat (40) rand_cycle(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < HOLD + 5; i++) begin
      rand_cycle(1'b1, 1'b0, 1'b1);
      rand_cycle(1'b0, 1'b0, 1'b1);
    end

    $display("[TB] reset in prompt");
    applyStimulus(X0 + 3, Y0 + 3, 0, 0, 0, 0, 0, 0, 0, 1);
    repeat (2) rand_cycle(1'b0, 1'b0, 1'b0);
    applyStimulus(X0, Y0, 0, 0, 1, 0, 0, 0, 16, 0);
    repeat (40) rand_cycle(1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/text_prompt_screen.md
Name: text_prompt_screen

Overview:
- Parametrised successor to the fixed-string "switch players" screen.
- Renders a run-time-loaded ASCII string at a configurable position and integer scale over a solid background.
- Adds a frame-counted hold phase, a blinking prompt phase, and a key-acknowledge handshake that tells the game FSM to continue.
- Sits between the VGA controller and the colour mux; shares the synchronous font ROM (1-cycle read latency).

Parameters:
- MAX_CHARS, 16, string buffer depth (2..32).
- SCALE_LOG2, 2, glyph scale = 1<<SCALE_LOG2 in both axes (0..3).
- X0, 100, left pixel of text box.
- Y0, 100, top pixel of text box.
- HOLD_FRAMES, 60, frames text is shown steady before the prompt phase (>=1).
- BLINK_FRAMES, 30, frames per blink half-period (>=1).

Ports:
- clk  in  1  pixel/system clock
- reset  in  1  synchronous, active-high
- frame_start  in  1  one-cycle pulse per frame (start of vblank)
- DrawX  in  10  current pixel X
- DrawY  in  10  current pixel Y
- font_data  in  8  font ROM row, valid 1 cycle after font_address
- font_address  out  11  {ascii,4'b0}+row
- Red  out  4  registered pixel colour
- Green  out  4  registered pixel colour
- Blue  out  4  registered pixel colour
- wr_en  in  1  write one character to the buffer
- wr_idx  in  $clog2(MAX_CHARS)  buffer index
- wr_char  in  7  ASCII code
- str_len  in  $clog2(MAX_CHARS+1)  visible length, latched on show
- show  in  1  start-display pulse
- key_pressed  in  1  acknowledge pulse from the keyboard
- busy  out  1  high whenever state != IDLE
- continue_pulse  out  1  one-cycle pulse when the user acknowledges

Behaviour:
Reset:
- state=IDLE; buffer filled with ASCII 32.
- Latched length = 0; frame counter = 0.
- font_address=0, RGB=background (3,6,2), busy=0, continue_pulse=0.
- Reset asserted in any state returns to IDLE with no continue_pulse.

FSM:
- IDLE: show -> HOLD; latch str_len, clamped to MAX_CHARS; clear counter.
- HOLD: text steady. Count frame_start pulses; after the HOLD_FRAMES-th pulse -> PROMPT with counter cleared. key_pressed is ignored.
- PROMPT:
  - Text is visible while blink phase = 0.
  - Phase toggles every BLINK_FRAMES frame_start pulses; it starts at 0 (visible).
  - key_pressed -> ACK. If key_pressed and frame_start arrive in the same cycle, the key wins.
- ACK: continue_pulse=1 for exactly this cycle -> IDLE.

Handshake rules:
- show outside IDLE is ignored.
- wr_en is accepted only in IDLE (buffer locked while busy).
- wr_idx >= MAX_CHARS is ignored.

Render pipeline (2-cycle latency, DrawX/DrawY -> RGB):
- Stage 0:
  - The box is in range when DrawX in [X0, X0 + len*(8<<SCALE_LOG2)) and DrawY in [Y0, Y0 + (16<<SCALE_LOG2)).
  - char = (DrawX-X0)>>(3+SCALE_LOG2)
  - col = ((DrawX-X0)>>SCALE_LOG2)&7
  - row = ((DrawY-Y0)>>SCALE_LOG2)&15
  - font_address = {buf[char],4'b0}+row when in box, else 0.
  - Register in_box, col and text_enable (state HOLD, or PROMPT with phase 0).
- Stage 1: pixel_on = in_box_d & text_enable_d & font_data[7-col_d]. Register RGB: (E,E,C) if on, else background.
- Subtraction is 10-bit unsigned and performed only when in range; no wrap-around.
- len=0 draws nothing.
- IDLE draws background only.

Optional Feature:
- Macro: TEXT_PROMPT_BORDER_EN.
- Defined: a 2-pixel border of colour (E,E,C) is drawn just outside the text box (the box expanded by 2 on every side) whenever state != IDLE and len>0. It is registered through the same 2-cycle pipeline and is unaffected by blink.
- Undefined: no border logic is built; output is identical to the spec above.

Decomposition:
- Package text_screen_pkg holds:
  - state enum {IDLE,HOLD,PROMPT,ACK}
  - colour constants BG_R/G/B, FG_R/G/B
  - ASCII_SPACE=7'd32, FONT_ROWS=16, GLYPH_W=8
- Sub-module text_pixel_pipe holds the stage-0/stage-1 render path: inputs are coordinates, buffer read data and text_enable; output is RGB. The FSM and buffer stay in the top level.

Test Plan:
- Reset with X/Y=(X0,Y0) -> RGB=(3,6,2), font_address=0, busy=0 for all cycles.
- Load "OK" (79,75), str_len=2, show, SCALE_LOG2=2; DrawX=100, DrawY=104 -> font_address=79*16+1=1265 the same cycle. RGB reflects font_data bit 7 two cycles later; DrawX=132 -> address 75*16+0.
- In HOLD, pulse key_pressed -> no continue_pulse. After exactly 60 frame_start pulses -> PROMPT, text still visible.
- In PROMPT with BLINK_FRAMES=30: after 30 frames text pixels show background; after 60 frames text is visible again.
- key_pressed together with frame_start in PROMPT -> continue_pulse high exactly one cycle, busy=0 the next cycle. A second show is accepted; show/wr_en while busy -> no effect.
- reset mid-PROMPT -> IDLE, no continue_pulse, buffer all spaces. With TEXT_PROMPT_BORDER_EN, pixel (X0-1,Y0) -> (E,E,C) while busy.
